// File: rtl/storage_pkg.sv
// storage_pkg: shared storage types, the SRAM address limit and the byte-enable merge helper.
package storage_pkg;
   localparam logic [31:0] SRAM_LIMIT = 32'h0000_0FFF;
   typedef enum logic [2:0] {IDLE, ISSUE, RMW_RD, RMW_GAP, RMW_WR, RESP} state_t;
   function automatic logic [31:0] be_merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                            input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
      return m;
   endfunction
endpackage

// File: rtl/mem_bridge.sv
// mem_bridge: turns core mem_* requests into storage controller sc_* accesses.
//   clk, rst (sync, active-low)
//   mem_req/mem_gnt/mem_addr/mem_we/mem_be/mem_wdata : core request side
//   mem_rvalid/mem_err/mem_rdata                      : one-cycle core response
//   sc_access/sc_is_writing/sc_addr/sc_d_in/sc_be     : controller command (registered)
//   sc_d_out/sc_out_valid                             : controller completion
module mem_bridge
   import storage_pkg::*;
#(
   parameter int          MEM_W      = 32,
   parameter int          TIMEOUT    = 1024,
   parameter logic [31:0] SRAM_LIMIT = storage_pkg::SRAM_LIMIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_req,
   output logic               mem_gnt,
   input  logic [31:0]        mem_addr,
   input  logic               mem_we,
   input  logic [MEM_W/8-1:0] mem_be,
   input  logic [MEM_W-1:0]   mem_wdata,
   output logic               mem_rvalid,
   output logic               mem_err,
   output logic [MEM_W-1:0]   mem_rdata,
   output logic               sc_access,
   output logic               sc_is_writing,
   output logic [31:0]        sc_addr,
   output logic [31:0]        sc_d_in,
   output logic [MEM_W/8-1:0] sc_be,
   input  logic [31:0]        sc_d_out,
   input  logic               sc_out_valid
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t             r_state;
   logic               r_imm, r_we, r_sc_access, r_sc_wr, r_prev_access, r_rvalid, r_err;
   logic [31:0]        r_addr;
   logic [MEM_W/8-1:0] r_be;
   logic [MEM_W-1:0]   r_wdata, r_rdata;
   logic [CW-1:0]      r_cnt;
   logic [31:0]        w_addr;
   logic               w_rise, w_to;
   assign w_addr        = mem_addr & 32'hFFFF_FFFC;
   assign w_rise        = r_sc_access & ~r_prev_access;
   // the rising-edge cycle itself restarts the count, so a stale count never times out
   assign w_to          = r_sc_access & ~w_rise & (r_cnt == CW'(TIMEOUT - 1));
   assign mem_gnt       = rst & mem_req & (r_state == IDLE);
   assign mem_rvalid    = r_rvalid;
   assign mem_err       = r_err;
   assign mem_rdata     = r_rdata;
   assign sc_access     = r_sc_access;
   assign sc_is_writing = r_sc_wr;
   assign sc_addr       = r_addr;
   assign sc_d_in       = r_wdata;
   assign sc_be         = {(MEM_W/8){r_sc_access}};
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_prev_access <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_prev_access <= r_sc_access;
         r_cnt         <= w_rise ? '0 : r_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_imm       <= 1'b0;
         r_we        <= 1'b0;
         r_sc_access <= 1'b0;
         r_sc_wr     <= 1'b0;
         r_rvalid    <= 1'b0;
         r_err       <= 1'b0;
         r_addr      <= '0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_rvalid <= 1'b0;
               if (mem_gnt) begin
                  r_addr  <= w_addr;
                  r_we    <= mem_we;
                  r_be    <= mem_be;
                  r_wdata <= mem_wdata;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
                  // immediate responses park one extra cycle in RESP via r_imm
                  if (mem_we && mem_be == '0) begin
                     r_state <= RESP;
                     r_imm   <= 1'b1;
                  end else if (mem_we && mem_addr >= SRAM_LIMIT) begin
                     r_state <= RESP;
                     r_imm   <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (mem_we && !(&mem_be)) begin
                     r_state     <= RMW_RD;
                     r_sc_access <= 1'b1;
                     r_sc_wr     <= 1'b0;
                  end else begin
                     r_state     <= ISSUE;
                     r_sc_access <= 1'b1;
                     r_sc_wr     <= mem_we;
                  end
               end
            end
            ISSUE, RMW_WR: begin
               if (sc_out_valid || w_to) begin
                  r_state     <= RESP;
                  r_sc_access <= 1'b0;
                  r_sc_wr     <= 1'b0;
                  r_rvalid    <= 1'b1;
                  r_err       <= ~sc_out_valid;
                  r_rdata     <= (sc_out_valid && !r_we) ? sc_d_out : '0;
               end
            end
            RMW_RD: begin
               if (sc_out_valid) begin
                  r_state     <= RMW_GAP;
                  r_sc_access <= 1'b0;
                  r_wdata     <= be_merge(sc_d_out, r_wdata, r_be);
               end else if (w_to) begin
                  r_state     <= RESP;
                  r_sc_access <= 1'b0;
                  r_rvalid    <= 1'b1;
                  r_err       <= 1'b1;
               end
            end
            RMW_GAP: begin
               r_state     <= RMW_WR;
               r_sc_access <= 1'b1;
               r_sc_wr     <= 1'b1;
            end
            RESP: begin
               if (r_imm) begin
                  r_imm    <= 1'b0;
                  r_rvalid <= 1'b1;
               end else begin
                  r_state  <= IDLE;
                  r_rvalid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
